pc_fetch_unit: RTL

- Parametrised program-counter unit that generalises the PC+4 adder into a registered fetch-address generator.
- Holds the PC register and computes the sequential next address.
- Arbitrates jump and branch redirects, honours pipeline stall, and buffers a redirect that arrives while stalled.
- Sits at the front of the pipeline and drives the instruction-memory address and the IF/ID flush.

---
 rtl/pc_fetch_unit.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: registered program-counter / fetch-address generator.
//
// Holds the fetch PC, produces the sequential PC+INC address, arbitrates
// jump over taken-branch redirects, holds the PC while the pipeline is
// stalled and buffers the newest redirect seen during a stall so that it
// is applied when the stall drops. A one-cycle flush pulse marks every PC
// load that came from a redirect so the IF/ID stage can be squashed.
//
// Build option (macro): MISALIGN_TRAP_EN
//   undefined : redirect targets have bits [1:0] forced to zero.
//   defined   : a redirect target with bits [1:0] != 0 loads TRAP_PC
//               instead and pulses the extra misalign output.

module pc_fetch_unit #(
  parameter int PC_WIDTH = 10,
  parameter int INC      = 4,
  parameter int RESET_PC = 0
`ifdef MISALIGN_TRAP_EN
  , parameter int TRAP_PC = 0
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] PC,
  output logic [PC_WIDTH-1:0] siguiente,
  output logic                valid,
  output logic                flush
`ifdef MISALIGN_TRAP_EN
  , output logic              misalign
`endif
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] INC_V      = PC_WIDTH'(INC);
  localparam logic [PC_WIDTH-1:0] RESET_V    = PC_WIDTH'(RESET_PC);
`ifdef MISALIGN_TRAP_EN
  localparam logic [PC_WIDTH-1:0] TRAP_V     = PC_WIDTH'(TRAP_PC);
`else
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);
`endif

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_d;
  logic                  flush_d;
  logic                  pending_valid_q, pending_valid_d;
  logic [PC_WIDTH-1:0]   pending_target_q, pending_target_d;

  logic                  live_redir;
  logic [PC_WIDTH-1:0]   live_target;
  logic [PC_WIDTH-1:0]   sel_target;
  logic [PC_WIDTH-1:0]   load_target;
  logic                  target_bad;

`ifdef MISALIGN_TRAP_EN
  logic                  misalign_d;
`endif

  // Sequential address wraps modulo 2^PC_WIDTH and is never gated by reset.
  assign siguiente = PC + INC_V;

  // Live redirect: jump outranks a taken branch.
  assign live_redir  = jump | branch_taken;
  assign live_target = jump ? jump_target : branch_target;

  // A live redirect beats a buffered one when the stall is released.
  assign sel_target = (state_q == S_HOLD && pending_valid_q && !live_redir)
                      ? pending_target_q : live_target;

`ifdef MISALIGN_TRAP_EN
  // Misaligned redirect targets divert to the trap vector.
  assign target_bad  = |sel_target[1:0];
  assign load_target = target_bad ? TRAP_V : sel_target;
`else
  // Redirect targets are word-aligned by dropping the low two bits.
  assign target_bad  = 1'b0;
  assign load_target = sel_target & ALIGN_MASK;
`endif

  // State register; reset forces the boot state without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_BOOT;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of block ordering.
      state_q <= state_d;
    end
  end

  // Next-state logic: boot for one edge, then run, parking in hold while a
  // redirect is buffered behind a stall.
  always_comb begin
    // NOTE: a default on every path keeps this block purely combinational;
    // leaving any branch unassigned would infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (stall && live_redir) state_d = S_HOLD;
      S_HOLD:  if (!stall) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
  end

  // Datapath next values: PC, flush pulse and the pending-redirect buffer.
  always_comb begin
    pc_d             = PC;
    flush_d          = 1'b0;
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d       = 1'b0;
`endif
    unique case (state_q)
      S_BOOT: begin
        pc_d = PC;
      end
      S_RUN: begin
        if (!stall) begin
          if (live_redir) begin
            pc_d    = load_target;
            flush_d = 1'b1;
`ifdef MISALIGN_TRAP_EN
            misalign_d = target_bad;
`endif
          end else begin
            pc_d = siguiente;
          end
        end else if (live_redir) begin
          pending_target_d = live_target;
          pending_valid_d  = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          pc_d            = load_target;
          flush_d         = 1'b1;
          pending_valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign_d      = target_bad;
`endif
        end else if (live_redir) begin
          pending_target_d = live_target;
        end
      end
      default: begin
        pending_valid_d = 1'b0;
      end
    endcase
  end

  // Datapath registers; reset discards any buffered or same-cycle redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC               <= RESET_V;
      flush            <= 1'b0;
      pending_valid_q  <= 1'b0;
      pending_target_q <= '0;
    end else begin
      PC               <= pc_d;
      flush            <= flush_d;
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // Trap indicator, pulses alongside the flush of a trapped redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign <= 1'b0;
    else     misalign <= misalign_d;
  end
`endif

  // Fetch address is legal once the boot edge has passed.
  assign valid = (state_q != S_BOOT);

endmodule
